// File: rtl/uart_core_param_if.sv
// Valid/ready handshake and serial-line bundle for uart_core_param.
interface uart_core_param_if;
  logic       rx_data;
  logic       tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_byte;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  // UART core side
  modport slave (
    input  rx_data, tx_valid, tx_byte, rx_ready,
    output tx_data, tx_ready, rx_valid, rx_byte, parity_err, frame_err, overrun
  );

  // Consumer / line side
  modport master (
    output rx_data, tx_valid, tx_byte, rx_ready,
    input  tx_data, tx_ready, rx_valid, rx_byte, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/uart_core_param.sv
// Full-duplex UART: configurable data width, parity, stop bits and baud.
// RX oversamples 16x and holds one received byte with error/overrun flags.
module uart_core_param #(
  parameter int CLK_HZ    = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk_in,
  input  logic              reset,
  uart_core_param_if.slave  bus
);
  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t           tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [3:0]       tx_tick_q, tx_tick_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_par_q, tx_par_d;
  logic             tx_stop_q, tx_stop_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_tick;
  logic [7:0]       tx_masked;

  assign tx_tick   = (tx_div_q == DIV_LAST);
  assign tx_masked = bus.tx_byte & DATA_MASK;

  // TX next state: the line value for the next bit is registered so tx_data is glitch-free
  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_tick ? '0 : tx_div_q + 1'b1;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_line_d  = tx_line_q;
    if (tx_state_q == S_IDLE) begin
      tx_line_d = 1'b1;
      if (bus.tx_valid) begin
        tx_shift_d = tx_masked;
        tx_par_d   = (^tx_masked) ^ PAR_ODD;
        tx_state_d = S_START;
        tx_div_d   = '0;
        tx_tick_d  = '0;
        tx_line_d  = 1'b0;
      end
    end else if (tx_tick) begin
      tx_tick_d = tx_tick_q + 4'd1;
      if (tx_tick_q == 4'hf) begin
        case (tx_state_q)
          S_START: begin
            tx_state_d = S_DATA;
            tx_bit_d   = '0;
            tx_line_d  = tx_shift_q[0];
          end
          S_DATA: begin
            if (tx_bit_q == LAST_BIT) begin
              tx_stop_d = 1'b0;
              if (PARITY != 0) begin
                tx_state_d = S_PARITY;
                tx_line_d  = tx_par_q;
              end else begin
                tx_state_d = S_STOP;
                tx_line_d  = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + 3'd1;
              tx_shift_d = tx_shift_q >> 1;
              tx_line_d  = tx_shift_q[1];
            end
          end
          S_PARITY: begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end
          S_STOP: begin
            if (tx_stop_q == LAST_STOP) tx_state_d = S_IDLE;
            else tx_stop_d = 1'b1;
          end
          default: tx_state_d = S_IDLE;
        endcase
      end
    end
  end

  // TX state register; reset leaves the line idle high
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tx_state_q <= S_IDLE;
      tx_div_q   <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign bus.tx_data  = tx_line_q;
  assign bus.tx_ready = (tx_state_q == S_IDLE);

  // ---------------- receiver ----------------
  state_t           rx_state_q, rx_state_d;
  logic [2:0]       rx_sync_q, rx_sync_d;   // [1] = synchronised line, [2] = its previous value
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [3:0]       rx_tick_q, rx_tick_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_par_q, rx_par_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             rx_tick, rx_line, rx_fall;
  logic [7:0]       rx_aligned;

  assign rx_tick    = (rx_div_q == DIV_LAST);
  assign rx_line    = rx_sync_q[1];
  // Edge detection needs a real high->low step, so a line stuck low never re-arms
  assign rx_fall    = rx_sync_q[2] & ~rx_sync_q[1];
  // Bits enter at the MSB, so a short frame ends up left-aligned
  assign rx_aligned = rx_shift_q >> (8 - DATA_BITS);

  // RX next state, sampling, and holding-register handshake
  always_comb begin
    rx_sync_d  = {rx_sync_q[1:0], bus.rx_data};
    rx_state_d = rx_state_q;
    rx_div_d   = rx_tick ? '0 : rx_div_q + 1'b1;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_d = S_START;
          rx_div_d   = '0;
          rx_tick_d  = '0;
        end
      end
      S_START: begin
        if (rx_tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'd7) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_line ? S_IDLE : S_DATA;
          end
        end
      end
      default: begin
        if (rx_tick) begin
          rx_tick_d = rx_tick_q + 4'd1;
          if (rx_tick_q == 4'hf) begin
            case (rx_state_q)
              S_DATA: begin
                rx_shift_d = {rx_line, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
              end
              S_PARITY: begin
                rx_par_d   = rx_line;
                rx_state_d = S_STOP;
              end
              default: begin
                // First stop sample completes the frame; a second stop bit is not awaited
                rx_state_d = S_IDLE;
                if (rx_valid_q) begin
                  ovr_d = 1'b1;
                end else begin
                  rx_valid_d = 1'b1;
                  rx_byte_d  = rx_aligned;
                  perr_d     = (PARITY != 0) && (rx_par_q != ((^rx_aligned) ^ PAR_ODD));
                  ferr_d     = ~rx_line;
                end
              end
            endcase
          end
        end
      end
    endcase
  end

  // RX state register; synchroniser resets to the idle-high line level
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_state_q <= S_IDLE;
      rx_sync_q  <= 3'b111;
      rx_div_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sync_q  <= rx_sync_d;
      rx_div_q   <= rx_div_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_byte    = rx_byte_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three configurations (8N1/DIV1, 8E1/DIV1, 7O2/DIV2)
// checked against a frame-level reference model, directed vectors and random traffic.
module tb_uart_core_param;
  localparam int NCFG   = 3;
  localparam int CLK_HZ = 1600000;

  function automatic int baud_of(input int k);
    case (k) 2: return 50000; default: return 100000; endcase
  endfunction
  function automatic int db_of(input int k);
    case (k) 2: return 7; default: return 8; endcase
  endfunction
  function automatic int par_of(input int k);
    case (k) 1: return 2; 2: return 1; default: return 0; endcase
  endfunction
  function automatic int sb_of(input int k);
    case (k) 2: return 2; default: return 1; endcase
  endfunction
  function automatic int bitc(input int k);
    return 16 * (CLK_HZ / (baud_of(k) * 16));
  endfunction
  function automatic logic [7:0] mask_of(input int k);
    return 8'((1 << db_of(k)) - 1);
  endfunction
  function automatic int frame_len(input int k);
    return 1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k);
  endfunction

  // Reference model: line level of each bit of a frame, bit 0 = start
  function automatic logic [15:0] frame_bits(input int k, input logic [7:0] d,
                                             input bit bad_par, input bit bad_stop);
    logic [15:0] fb;
    logic p;
    int idx;
    fb = '1;
    fb[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < db_of(k); i++) begin
      fb[1 + i] = d[i];
      p = p ^ d[i];
    end
    idx = 1 + db_of(k);
    if (par_of(k) != 0) begin
      if (par_of(k) == 1) p = ~p;
      fb[idx] = p ^ bad_par;
      idx++;
    end
    for (int j = 0; j < sb_of(k); j++) fb[idx + j] = ~bad_stop;
    return fb;
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [NCFG-1:0] tx_valid, rx_ready, rx_drv, loop_sel;
  logic [NCFG-1:0][7:0] tx_byte_i;
  logic [NCFG-1:0] tx_data_o, tx_ready_o, rx_valid_o, perr_o, ferr_o, ovr_o;
  logic [NCFG-1:0][7:0] rx_byte_o;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    uart_core_param_if bus_if ();
    assign bus_if.tx_valid = tx_valid[gi];
    assign bus_if.tx_byte  = tx_byte_i[gi];
    assign bus_if.rx_ready = rx_ready[gi];
    assign bus_if.rx_data  = loop_sel[gi] ? bus_if.tx_data : rx_drv[gi];
    assign tx_data_o[gi]   = bus_if.tx_data;
    assign tx_ready_o[gi]  = bus_if.tx_ready;
    assign rx_valid_o[gi]  = bus_if.rx_valid;
    assign rx_byte_o[gi]   = bus_if.rx_byte;
    assign perr_o[gi]      = bus_if.parity_err;
    assign ferr_o[gi]      = bus_if.frame_err;
    assign ovr_o[gi]       = bus_if.overrun;
    uart_core_param #(
      .CLK_HZ(CLK_HZ), .BAUD(baud_of(gi)), .DATA_BITS(db_of(gi)),
      .PARITY(par_of(gi)), .STOP_BITS(sb_of(gi))
    ) u_dut (
      .clk_in(clk),
      .reset (rst_n),
      .bus   (bus_if)
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RX observation captured while stimulus runs
  int         cap_rise, cap_ovr;
  logic [7:0] cap_byte;
  logic       cap_perr, cap_ferr, cap_prev;

  task automatic clear_cap(input int k);
    cap_rise = 0; cap_ovr = 0; cap_byte = '0; cap_perr = 1'b0; cap_ferr = 1'b0;
    cap_prev = rx_valid_o[k];
  endtask

  task automatic poll(input int k);
    if (rx_valid_o[k] && !cap_prev) begin
      cap_rise++;
      if (cap_rise == 1) begin
        cap_byte = rx_byte_o[k]; cap_perr = perr_o[k]; cap_ferr = ferr_o[k];
      end
    end
    cap_prev = rx_valid_o[k];
    if (ovr_o[k]) cap_ovr++;
  endtask

  task automatic accept_tx(input int k, input logic [7:0] d);
    int t;
    @(negedge clk);
    for (t = 0; t < 2000 && !tx_ready_o[k]; t++) @(negedge clk);
    chk("tx_accept_wait", tx_ready_o[k], 1'b1);
    tx_byte_i[k] = d;
    tx_valid[k]  = 1'b1;
    @(posedge clk);
    #1 tx_byte_i[k] = ~d;   // latched copy must be used from here on
  endtask

  // Send through loopback; compare the whole line waveform against the model
  task automatic send_check(input int k, input logic [7:0] d);
    logic [15:0] fb;
    int n, b, bad, first_bad;
    fb = frame_bits(k, d, 1'b0, 1'b0);
    n = frame_len(k); b = bitc(k); bad = 0; first_bad = -1;
    loop_sel[k] = 1'b1;
    clear_cap(k);
    accept_tx(k, d);
    for (int s = 0; s <= n * b; s++) begin
      @(negedge clk);
      poll(k);
      if (s < n * b && tx_data_o[k] !== fb[s / b]) begin
        if (bad == 0) first_bad = s;
        bad++;
      end
      if (s == n * b - 1) begin
        chk("tx_ready_busy_last", tx_ready_o[k], 1'b0);
        tx_valid[k] = 1'b0;
      end
    end
    chk("tx_ready_after_stop", tx_ready_o[k], 1'b1);
    chk("tx_wave_bad_slots", bad, 0);
    if (bad != 0) $display("  first differing slot %0d (cfg %0d byte 0x%0h)", first_bad, k, d);
    repeat (4) begin @(negedge clk); poll(k); end
  endtask

  // Drive a frame directly onto rx_data; a low stop leaves the line low for a while
  task automatic drive_rx(input int k, input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic [15:0] fb;
    int n, b;
    fb = frame_bits(k, d, bad_par, bad_stop);
    n = frame_len(k); b = bitc(k);
    loop_sel[k] = 1'b0;
    clear_cap(k);
    for (int s = 0; s < n * b; s++) begin
      @(negedge clk); rx_drv[k] = fb[s / b]; poll(k);
    end
    if (bad_stop) for (int s = 0; s < (n + 1) * b; s++) begin @(negedge clk); poll(k); end
    rx_drv[k] = 1'b1;
    for (int s = 0; s < 2 * b; s++) begin @(negedge clk); poll(k); end
  endtask

  task automatic check_rx(input string nm, input logic [7:0] eb, input bit ep, input bit ef);
    chk({nm, "_valid_count"}, cap_rise, 1);
    chk({nm, "_byte"}, cap_byte, eb);
    chk({nm, "_parity_err"}, cap_perr, ep);
    chk({nm, "_frame_err"}, cap_ferr, ef);
    chk({nm, "_overrun"}, cap_ovr, 0);
  endtask

  typedef struct {
    int         cfg;
    bit         loopback;
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_byte;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit bp, bs;
    vecs[0] = '{cfg: 0, loopback: 1, data: 8'hA5, bad_par: 0, bad_stop: 0, exp_byte: 8'hA5, exp_perr: 0, exp_ferr: 0};
    vecs[1] = '{cfg: 1, loopback: 1, data: 8'h3C, bad_par: 0, bad_stop: 0, exp_byte: 8'h3C, exp_perr: 0, exp_ferr: 0};
    vecs[2] = '{cfg: 2, loopback: 1, data: 8'h7F, bad_par: 0, bad_stop: 0, exp_byte: 8'h7F, exp_perr: 0, exp_ferr: 0};
    vecs[3] = '{cfg: 2, loopback: 1, data: 8'hFF, bad_par: 0, bad_stop: 0, exp_byte: 8'h7F, exp_perr: 0, exp_ferr: 0};
    vecs[4] = '{cfg: 1, loopback: 0, data: 8'h55, bad_par: 1, bad_stop: 0, exp_byte: 8'h55, exp_perr: 1, exp_ferr: 0};
    vecs[5] = '{cfg: 1, loopback: 0, data: 8'h12, bad_par: 0, bad_stop: 1, exp_byte: 8'h12, exp_perr: 0, exp_ferr: 1};
    vecs[6] = '{cfg: 2, loopback: 0, data: 8'hDA, bad_par: 1, bad_stop: 1, exp_byte: 8'h5A, exp_perr: 1, exp_ferr: 1};

    rst_n = 1'b0;
    tx_valid = '0; rx_ready = '1; rx_drv = '1; loop_sel = '1; tx_byte_i = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NCFG; k++) begin
      chk("reset_tx_data", tx_data_o[k], 1'b1);
      chk("reset_tx_ready", tx_ready_o[k], 1'b1);
      chk("reset_rx_valid", rx_valid_o[k], 1'b0);
      chk("reset_rx_byte", rx_byte_o[k], 8'h00);
      chk("reset_parity_err", perr_o[k], 1'b0);
      chk("reset_frame_err", ferr_o[k], 1'b0);
      chk("reset_overrun", ovr_o[k], 1'b0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].loopback) send_check(vecs[v].cfg, vecs[v].data);
      else drive_rx(vecs[v].cfg, vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop);
      $display("vec %0d cfg %0d data 0x%0h -> rx 0x%0h perr %0d ferr %0d", v, vecs[v].cfg,
               vecs[v].data, cap_byte, cap_perr, cap_ferr);
      check_rx("vec", vecs[v].exp_byte, vecs[v].exp_perr, vecs[v].exp_ferr);
    end

    // Overrun: hold the first byte, second frame is dropped with a single pulse
    rx_ready[1] = 1'b0;
    drive_rx(1, 8'h11, 1'b0, 1'b0);
    chk("ovr_first_valid", cap_rise, 1);
    chk("ovr_first_byte", cap_byte, 8'h11);
    chk("ovr_first_no_pulse", cap_ovr, 0);
    drive_rx(1, 8'h22, 1'b0, 1'b0);
    chk("ovr_pulse_count", cap_ovr, 1);
    chk("ovr_held_valid", rx_valid_o[1], 1'b1);
    chk("ovr_held_byte", rx_byte_o[1], 8'h11);
    rx_ready[1] = 1'b1;
    @(negedge clk);
    chk("ovr_valid_cleared", rx_valid_o[1], 1'b0);
    $display("overrun sequence: held 0x%0h, pulses %0d", rx_byte_o[1], cap_ovr);

    // Glitch: 4-clock low pulse is a false start
    loop_sel[0] = 1'b0;
    clear_cap(0);
    @(negedge clk); rx_drv[0] = 1'b0;
    repeat (4) begin @(negedge clk); poll(0); end
    rx_drv[0] = 1'b1;
    repeat (3 * bitc(0)) begin @(negedge clk); poll(0); end
    chk("glitch_no_valid", cap_rise, 0);
    drive_rx(0, 8'hC3, 1'b0, 1'b0);
    check_rx("after_glitch", 8'hC3, 1'b0, 1'b0);
    $display("glitch then frame: rx 0x%0h", cap_byte);

    // Random traffic against the model
    for (int k = 0; k < NCFG; k++) begin
      for (int r = 0; r < 6; r++) begin
        d = 8'($urandom);
        if ($urandom_range(1, 0) == 1) begin
          send_check(k, d);
          $display("rnd loop cfg %0d data 0x%0h -> rx 0x%0h", k, d, cap_byte);
          check_rx("rnd_loop", d & mask_of(k), 1'b0, 1'b0);
        end else begin
          bp = (par_of(k) != 0) ? 1'($urandom_range(1, 0)) : 1'b0;
          bs = ($urandom_range(3, 0) == 0);
          drive_rx(k, d, bp, bs);
          $display("rnd drv cfg %0d data 0x%0h bp %0d bs %0d -> rx 0x%0h", k, d, bp, bs, cap_byte);
          check_rx("rnd_drv", d & mask_of(k), bp, bs);
        end
      end
    end

    // Reset in the middle of bit 3 of a transmission
    loop_sel[0] = 1'b1;
    accept_tx(0, 8'h96);
    tx_valid[0] = 1'b0;
    repeat (3 * bitc(0) + 5) @(negedge clk);
    chk("pre_reset_busy", tx_ready_o[0], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_data", tx_data_o[0], 1'b1);
    chk("midreset_tx_ready", tx_ready_o[0], 1'b1);
    chk("midreset_rx_valid", rx_valid_o[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_check(0, 8'h96);
    check_rx("post_reset", 8'h96, 1'b0, 1'b0);
    $display("post-reset frame: rx 0x%0h", cap_byte);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised successor to the fixed 8N1 UART wrapper. Full-duplex UART with compile-time data width, parity mode, stop-bit count and baud rate. RX uses 16x oversampling and a one-entry holding register with error and overrun reporting. Both directions use valid/ready handshakes. Instantiated by the PID data path in place of the fixed-format receiver/transmitter pair.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/(BAUD*16), integer truncation, must be >= 1
DATA_BITS, 8, payload bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  1  serial line in (asynchronous)
tx_data  output  1  serial line out, idle high
tx_valid  input  1  tx_byte valid
tx_ready  output  1  TX idle, can accept a byte
tx_byte  input  8  byte to send; bits above DATA_BITS-1 ignored
rx_valid  output  1  rx_byte and flags valid
rx_ready  input  1  consumer accepts rx_byte
rx_byte  output  8  received byte, LSB-aligned; unused upper bits 0
parity_err  output  1  parity mismatch on held byte (0 if PARITY=0)
frame_err  output  1  stop bit sampled low on held byte
overrun  output  1  one-cycle pulse: frame completed while rx_valid high

Behaviour:
- Reset (reset=0, async): tx_data=1, tx_ready=1, rx_valid=0, rx_byte=0, parity_err=0, frame_err=0, overrun=0; both FSMs to IDLE; RX synchroniser flops = 1. Reset mid-frame aborts both directions immediately; no partial byte is delivered.
- Tick: each direction has its own divider producing a one-cycle tick every DIV clocks; one bit = 16 ticks = 16*DIV clocks.
- Frame order: start (0), DATA_BITS data bits LSB first, parity bit if PARITY!=0, STOP_BITS stop bits (1).
- Parity bit: even = XOR of data bits; odd = its inverse.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- TX handshake: accept on tx_valid & tx_ready. Byte is latched. tx_ready drops the cycle after acceptance. The TX divider restarts on acceptance, and tx_data goes low the cycle after acceptance.
- TX timing: each bit is held exactly 16*DIV clocks; STOP lasts STOP_BITS*16*DIV clocks. tx_ready reasserts the cycle after the final stop tick. tx_valid is ignored while busy.
- RX input: rx_data passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- RX IDLE -> START on a synchronised 1->0 transition; the RX divider restarts at that point.
- RX START: after 8 ticks, resample the line. If high, it is a false start: return to IDLE with no output. If low, go to DATA.
- RX DATA/PARITY/STOP: sample every 16 ticks (mid-bit). Only the first stop bit is checked; the second stop bit, if configured, is not waited for.
- RX completion, at the stop sample:
  - If rx_valid=0: load rx_byte, set parity_err and frame_err for this frame, and assert rx_valid next cycle.
  - If rx_valid=1: drop the new frame, keep the held byte and flags, and pulse overrun for 1 cycle.
  - Frames with errors are still delivered, with the flags set.
- RX after STOP: return to IDLE. If the line is low (break or framing error), wait for the line to go high before re-arming edge detection.
- RX handshake: rx_valid stays high until a cycle with rx_ready=1, then clears next cycle. A completion in that same cycle counts as rx_valid=1, i.e. overrun.
- TX and RX are fully independent; a loopback rx_data=tx_data must work.

Test Plan:
- Config CLK_HZ=1600000, BAUD=100000 (DIV=1), 8N1: send tx_byte=0xA5 -> tx_data low 16 clocks, then bits 1,0,1,0,0,1,0,1 each 16 clocks, then high 16 clocks; tx_ready=1 on clock 161 after acceptance.
- Loopback, 8E1: send 0x3C -> rx_valid with rx_byte=0x3C, parity_err=0, frame_err=0; parity bit on the line = 0. Repeat with 7O2 and 0x7F -> rx_byte=0x7F, parity bit 0, two stop bits observed on tx_data.
- Drive an RX frame 0x55 with the wrong parity bit (8E1) -> rx_valid, rx_byte=0x55, parity_err=1. Drive 0x12 with the stop bit low -> frame_err=1, and no new start is detected until the line returns high.
- Hold rx_ready=0, drive two frames 0x11 then 0x22 -> rx_byte stays 0x11, overrun pulses once at the second stop sample. Then rx_ready=1 -> rx_valid clears.
- Glitch: 4-clock low pulse on rx_data (DIV=1) -> false start, no rx_valid. Assert reset mid-TX at bit 3 -> tx_data=1, tx_ready=1 immediately, and the next send is a clean frame.
